// File: rtl/priority_decoder_pkg.sv
// Shared constants, FSM states and decode helpers for the priority
// encoder/decoder pair.
package prio_pkg;

    localparam int CODE_W   = 8;
    localparam int ONEHOT_W = 16;
    localparam int IDX_W    = 4;

    localparam logic [CODE_W-1:0] CODE_NONE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_e;

    // Only 0x00..0x0F carry an index; 0xF0 and everything else mean none.
    function automatic logic is_index(input logic [CODE_W-1:0] c);
        return c[CODE_W-1:IDX_W] == '0;
    endfunction

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [IDX_W-1:0] i);
        return ONEHOT_W'(1) << i;
    endfunction

endpackage

// File: rtl/priority_decoder_if.sv
// Pin-level bundle between the encoder link pads and the decoder.
// The decoder is the slave; the pad ring / bench is the master.
interface priority_decoder_if;
    import prio_pkg::*;

    logic              ena;
    logic [CODE_W-1:0] ui_in;
    logic [CODE_W-1:0] uio_in;
    logic [CODE_W-1:0] uo_out;
    logic [CODE_W-1:0] uio_out;
    logic [CODE_W-1:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/priority_decoder_code_qualifier.sv
// Two-flop synchronizer plus debounce counter; emits a one-cycle
// acceptance pulse once per stable run of DEBOUNCE identical samples.
module code_qualifier
    import prio_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    output logic              acc_valid,
    output logic [CODE_W-1:0] acc_code
);

    logic [CODE_W-1:0] s1;
    logic [CODE_W-1:0] s2;
    logic [CODE_W-1:0] cand;
    logic [7:0]        cnt;
    logic              same;

    assign same = (s2 == cand);

    // Pulse is high in the cycle before the edge where cnt hits DEBOUNCE.
    always_comb begin
        acc_valid = 1'b0;
        if (ena) begin
            if (same) acc_valid = (cnt == 8'(DEBOUNCE - 1));
            else      acc_valid = (DEBOUNCE == 1);
        end
    end

    assign acc_code = s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= CODE_NONE;
            s2   <= CODE_NONE;
            cand <= CODE_NONE;
            cnt  <= '0;
        end else if (ena) begin
            s1 <= code_in;
            s2 <= s1;
            if (!same) begin
                cand <= s2;
                cnt  <= 8'd1;
            end else if (cnt != 8'(DEBOUNCE)) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Regenerates the 16-bit one-hot request vector from the encoder code.
// Optional pulse stretching is built when PRIO_DEC_STRETCH_EN is defined.
module priority_decoder
    import prio_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int STRETCH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    priority_decoder_if.slave  bus
);

    logic                acc_valid;
    logic [CODE_W-1:0]   acc_code;
    state_e              state;
    logic [ONEHOT_W-1:0] onehot_q;
    logic [CODE_W-1:0]   oe_q;
    logic                unused_uio;

    assign unused_uio = ^bus.uio_in;

    code_qualifier #(
        .DEBOUNCE (DEBOUNCE)
    ) u_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (bus.ena),
        .code_in   (bus.ui_in),
        .acc_valid (acc_valid),
        .acc_code  (acc_code)
    );

`ifdef PRIO_DEC_STRETCH_EN
    logic [7:0]        scnt;
    logic              pend_vld;
    logic [CODE_W-1:0] pend_code;
    logic              nxt_vld;
    logic [CODE_W-1:0] nxt_code;

    // An acceptance on the expiry edge is newer than anything pending.
    assign nxt_vld  = acc_valid | pend_vld;
    assign nxt_code = acc_valid ? acc_code : pend_code;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            onehot_q <= '0;
`ifdef PRIO_DEC_STRETCH_EN
            scnt      <= '0;
            pend_vld  <= 1'b0;
            pend_code <= CODE_NONE;
`endif
        end else if (bus.ena) begin
            unique case (state)
                IDLE, ACTIVE: begin
                    if (acc_valid && is_index(acc_code)) begin
                        onehot_q <= onehot(acc_code[IDX_W-1:0]);
`ifdef PRIO_DEC_STRETCH_EN
                        state <= HOLD;
                        scnt  <= 8'(STRETCH);
`else
                        state <= ACTIVE;
`endif
                    end else if (acc_valid) begin
                        state    <= IDLE;
                        onehot_q <= '0;
                    end
                end
`ifdef PRIO_DEC_STRETCH_EN
                HOLD: begin
                    if (scnt != 8'd1) begin
                        scnt <= scnt - 8'd1;
                        if (acc_valid) begin
                            pend_vld  <= 1'b1;
                            pend_code <= acc_code;
                        end
                    end else begin
                        pend_vld <= 1'b0;
                        if (nxt_vld && is_index(nxt_code)) begin
                            onehot_q <= onehot(nxt_code[IDX_W-1:0]);
                            scnt     <= 8'(STRETCH);
                        end else if (nxt_vld) begin
                            state    <= IDLE;
                            onehot_q <= '0;
                        end else begin
                            state <= ACTIVE;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    onehot_q <= '0;
                end
            endcase
        end
    end

    // IO enables come up on the first edge out of reset, regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oe_q <= '0;
        else        oe_q <= 8'hFF;
    end

    assign bus.uo_out  = onehot_q[15:8];
    assign bus.uio_out = onehot_q[7:0];
    assign bus.uio_oe  = oe_q;

endmodule

// File: doc/priority_decoder.md
# priority_decoder

Inverse of the team's 16-input priority encoder: accepts the encoder's 8-bit output code on `ui_in` and regenerates the one-hot 16-bit request vector on `uo_out` (bits 15..8) and `uio_out` (bits 7..0). It sits on the receiving end of an encoder link, where the code arrives from off-chip pins. The input is synchronized and debounced before decoding, and an optional pulse-stretch mode is available.

## Interface
Parameters:
- `DEBOUNCE`, 3, consecutive identical synchronized samples required to accept a code (1..255).
- `STRETCH`, 8, minimum cycles a decoded one-hot is held in stretch mode (1..255).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable.
- `ui_in`  in  8  encoded code: 0x00..0x0F = index, 0xF0 = none.
- `uio_in`  in  8  unused.
- `uo_out`  out  8  one-hot bits 15..8 (`uo_out[i]` = index 8+i).
- `uio_out`  out  8  one-hot bits 7..0 (`uio_out[i]` = index i).
- `uio_oe`  out  8  IO enables.

## Operation
- **Input path:** `ui_in` passes through a 2-flop synchronizer, s1 then s2.
- **Qualifier:** holds a candidate register `cand` and a counter `cnt`.
  - If s2 ≠ `cand`: `cand` ← s2 and `cnt` ← 1.
  - Otherwise `cnt` increments, saturating at `DEBOUNCE`.
  - `cand` is accepted on the edge where `cnt` reaches `DEBOUNCE`, and only once per stable run.
- **Code classes:**
  - 0x00..0x0F → index = code[3:0].
  - 0xF0 → none.
  - Any other value → invalid, treated exactly as none.
- **FSM states:** IDLE (outputs all-zero) and ACTIVE (one-hot of the held index).
  - An accepted index moves the FSM to ACTIVE and loads the held index; this applies from both IDLE and ACTIVE.
  - An accepted none or invalid code moves the FSM to IDLE.
- **Exactly one** of the 16 output bits is set in ACTIVE; none is set in IDLE.
- **`uio_oe`:** registered; 0x00 in reset and 0xFF from the first edge after `rst_n` deasserts. It is unaffected by `ena`.
- **`ena` low:** synchronizer, qualifier, FSM and outputs all hold their values. On return, processing resumes from the held state.
- **Reset mid-operation:** all state clears immediately and asynchronously.

## Timing
- **Reset values:**
  - `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0x00.
  - FSM = IDLE, s1 = s2 = `cand` = 0xF0, `cnt` = 0.
- **Latency:** `ui_in` stable from before edge k gives new outputs just after edge k+DEBOUNCE+1 (k+4 at default).
- **Glitches:** a change that is stable for fewer than DEBOUNCE s2 samples produces no output change.
- **Re-presentation:** the same code presented again while already accepted causes no event.
- **Back-to-back changes:** each code that stays stable for DEBOUNCE samples is accepted, in order.

## Configuration
The feature is controlled by the macro `PRIO_DEC_STRETCH_EN`.
- **Without the macro:** behaviour is exactly as described in Operation. The stretch counter is not built.
- **With the macro:** a third state, HOLD, is added.
  - An accepted index loads the output and starts a down-counter at STRETCH, entering HOLD.
  - In HOLD, every accepted code (index, none or invalid) is latched into a single pending slot. A later acceptance overwrites the pending one.
  - When the counter expires, the pending code is applied: an index re-enters HOLD, none or invalid goes to IDLE. With no pending code, the FSM goes to ACTIVE.
  - Outputs therefore stay unchanged for at least STRETCH cycles after each load.
  - The pending slot resets to empty.

## Structure
- **Shared package `prio_pkg`:**
  - `CODE_NONE` = 8'hF0.
  - FSM state enum (IDLE, ACTIVE, HOLD).
  - Code width and one-hot width, 16. The encoder uses the same constants.
- **Sub-module `code_qualifier`:** contains the synchronizer plus debounce counter.
  - Outputs are `acc_valid` (a 1-cycle pulse) and `acc_code` (8 bits).
  - It is parameterized by `DEBOUNCE`.
- The top level keeps the FSM, the optional stretch counter and the one-hot decode.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACTIVE → outputs 0x00/0x00/0x00 immediately. After release, `uio_oe`=0xFF one edge later.
- **Basic decode:** `ui_in`=0x0F from before edge k → `uo_out`=0x80 and `uio_out`=0x00 after edge k+4. Then 0x03 → `uo_out`=0x00 and `uio_out`=0x08.
- **Glitch rejection:** hold 0x05, pulse `ui_in`=0x0A for 2 cycles → `uio_out` stays 0x20 throughout.
- **None and invalid:** 0xF0, then 0x55, then 0x1F → outputs 0x00/0x00 in every case, with the FSM in IDLE.
- **`ena` freeze:** while ACTIVE on 0x09, drop `ena` and apply 0x01 for 10 cycles → `uo_out`=0x02 held. Raise `ena` → `uio_out`=0x02 four edges later.
- **Stretch (macro defined):**
  - Apply 0x08 until it is accepted, then 0xF0 → `uo_out`=0x01 for exactly 8 cycles, then 0x00.
  - Applying 0x00 during HOLD → `uio_out`=0x01 from the first cycle after HOLD ends.
